// File: rtl/alu_pkg.sv
// +----------------------------------------------------------------+
// | alu_pkg : shared widths and opcode encoding for alu8_reg       |
// | Rev 1.0 : initial release                                      |
// +----------------------------------------------------------------+
`default_nettype none

package alu_pkg;

  localparam int WIDTH = 8;
  localparam int OPW   = 5;

  typedef enum logic [OPW-1:0] {
    OP_ADD    = 5'd0,
    OP_SUB    = 5'd1,
    OP_AND    = 5'd2,
    OP_OR     = 5'd3,
    OP_XOR    = 5'd4,
    OP_NOT    = 5'd5,
    OP_NEG    = 5'd6,
    OP_SHL    = 5'd7,
    OP_SHR    = 5'd8,
    OP_SHRA   = 5'd9,
    OP_ROL    = 5'd10,
    OP_ROR    = 5'd11,
    OP_MUL    = 5'd12,
    OP_DIV    = 5'd13,
    OP_PASS_A = 5'd14,
    OP_PASS_B = 5'd15
  } alu_op_t;

endpackage

`default_nettype wire

// File: rtl/alu8_shifter.sv
// +----------------------------------------------------------------+
// | alu8_shifter : combinational shift/rotate unit for alu8_reg    |
// | Rev 1.0 : initial release                                      |
// +----------------------------------------------------------------+
`default_nettype none

module alu8_shifter #(
  parameter int WIDTH = alu_pkg::WIDTH,
  parameter int OPW   = alu_pkg::OPW,
  parameter int SW    = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] a,
  input  logic [SW:0]      amt,
  input  logic [OPW-1:0]   op,
  output logic [WIDTH-1:0] res
);
  import alu_pkg::*;

  logic [2*WIDTH-1:0] w_dbl;
  logic [SW-1:0]      w_rot;

  assign w_dbl = {a, a};
  assign w_rot = amt[SW-1:0];

  // Shifts by >= WIDTH naturally yield zero (or sign fill for >>>).
  always_comb begin
    res = '0;
    case (op)
      OP_SHL:  res = a << amt;
      OP_SHR:  res = a >> amt;
      OP_SHRA: res = $unsigned($signed(a) >>> amt);
      OP_ROL:  res = WIDTH'((w_dbl << w_rot) >> WIDTH);
      OP_ROR:  res = WIDTH'(w_dbl >> w_rot);
      default: res = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu8_reg.sv
// +----------------------------------------------------------------+
// | alu8_reg : registered 8-bit ALU; ALU_MULDIV_EN builds MUL/DIV  |
// | Rev 1.0 : initial release                                      |
// +----------------------------------------------------------------+
`default_nettype none

module alu8_reg #(
  parameter int WIDTH = alu_pkg::WIDTH,
  parameter int OPW   = alu_pkg::OPW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [OPW-1:0]   in_c,
  output logic [WIDTH-1:0] out_res_rc,
  output logic [WIDTH-1:0] carryout
);
  import alu_pkg::*;

  localparam int SW = $clog2(WIDTH);

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_shift;
  logic [WIDTH-1:0] w_res;
  logic [WIDTH-1:0] w_aux;

  assign w_sum  = {1'b0, in_a} + {1'b0, in_b};
  assign w_diff = {1'b0, in_a} - {1'b0, in_b};

  alu8_shifter #(
    .WIDTH (WIDTH),
    .OPW   (OPW),
    .SW    (SW)
  ) u_shifter (
    .a   (in_a),
    .amt (in_b[SW:0]),
    .op  (in_c),
    .res (w_shift)
  );

`ifdef ALU_MULDIV_EN
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;

  assign w_prod = {{WIDTH{1'b0}}, in_a} * {{WIDTH{1'b0}}, in_b};
  // Divide-by-zero returns all ones and passes the dividend as remainder.
  assign w_quo  = (in_b == '0) ? '1   : in_a / in_b;
  assign w_rem  = (in_b == '0) ? in_a : in_a % in_b;
`endif

  always_comb begin
    w_res = '0;
    w_aux = '0;
    case (in_c)
      OP_ADD: begin
        w_res = w_sum[WIDTH-1:0];
        w_aux = {{(WIDTH-1){1'b0}}, w_sum[WIDTH]};
      end
      OP_SUB: begin
        w_res = w_diff[WIDTH-1:0];
        w_aux = {{(WIDTH-1){1'b0}}, w_diff[WIDTH]};
      end
      OP_AND:    w_res = in_a & in_b;
      OP_OR:     w_res = in_a | in_b;
      OP_XOR:    w_res = in_a ^ in_b;
      OP_NOT:    w_res = ~in_a;
      OP_NEG: begin
        w_res = '0 - in_a;
        w_aux = {{(WIDTH-1){1'b0}}, |in_a};
      end
      OP_SHL, OP_SHR, OP_SHRA, OP_ROL, OP_ROR: w_res = w_shift;
`ifdef ALU_MULDIV_EN
      OP_MUL: begin
        w_res = w_prod[WIDTH-1:0];
        w_aux = w_prod[2*WIDTH-1:WIDTH];
      end
      OP_DIV: begin
        w_res = w_quo;
        w_aux = w_rem;
      end
`endif
      OP_PASS_A: w_res = in_a;
      OP_PASS_B: w_res = in_b;
      default: begin
        w_res = '0;
        w_aux = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_res_rc <= '0;
      carryout   <= '0;
    end else begin
      out_res_rc <= w_res;
      carryout   <= w_aux;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu8_reg.sv
// +----------------------------------------------------------------+
// | tb_alu8_reg : self-checking bench for alu8_reg                 |
// | Rev 1.0 : initial release                                      |
// +----------------------------------------------------------------+
`default_nettype none

module tb_alu8_reg;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_a = '0;
  logic [7:0] in_b = '0;
  logic [4:0] in_c = '0;
  logic [7:0] out_res_rc;
  logic [7:0] carryout;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [4:0] op;
    logic [7:0] r;
    logic [7:0] c;
  } vec_t;

  alu8_reg dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_c       (in_c),
    .out_res_rc (out_res_rc),
    .carryout   (carryout)
  );

  always #5 clk = ~clk;

  // Reference model from the arithmetic definition of each opcode.
  function automatic void model(input int a, input int b, input int op,
                                output int r, output int c);
    int amt, k, sa, p, q;
    r = 0;
    c = 0;
    amt = b % 16;
    k = b % 8;
    case (op)
      0: begin r = (a + b) % 256; c = (a + b) / 256; end
      1: begin r = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = 255 - a;
      6: begin r = (256 - a) % 256; c = (a != 0) ? 1 : 0; end
      7: r = (amt >= 8) ? 0 : (a * (1 << amt)) % 256;
      8: r = (amt >= 8) ? 0 : a / (1 << amt);
      9: begin
        sa = (a >= 128) ? a - 256 : a;
        if (amt >= 8) r = (sa < 0) ? 255 : 0;
        else begin
          p = 1 << amt;
          q = (sa >= 0) ? sa / p : -((-sa + p - 1) / p);
          r = (q + 256) % 256;
        end
      end
      10: r = (a * (1 << k)) % 256 + a / (1 << (8 - k));
      11: r = a / (1 << k) + (a * (1 << (8 - k))) % 256;
`ifdef ALU_MULDIV_EN
      12: begin p = a * b; r = p % 256; c = p / 256; end
      13: begin
        if (b == 0) begin r = 255; c = a; end
        else begin r = a / b; c = a % b; end
      end
`endif
      14: r = a;
      15: r = b;
      default: begin r = 0; c = 0; end
    endcase
  endfunction

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [4:0] op);
    @(negedge clk);
    in_a = a;
    in_b = b;
    in_c = op;
  endtask

  task automatic test_reset;
    #2;
    n_checks++;
    if (out_res_rc !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_res: got %h want 00", out_res_rc);
    end
    n_checks++;
    if (carryout !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_aux: got %h want 00", carryout);
    end
    in_a = 8'h12; in_b = 8'h34; in_c = 5'd0;
    @(posedge clk); #1;
    n_checks++;
    if ({out_res_rc, carryout} !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_held: got %h/%h want 00/00", out_res_rc, carryout);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed;
    vec_t v[17];
    v[0]  = '{8'h05, 8'h02, 5'd0,  8'h07, 8'h00};
    v[1]  = '{8'hFF, 8'h01, 5'd0,  8'h00, 8'h01};
    v[2]  = '{8'h02, 8'h05, 5'd1,  8'hFD, 8'h01};
    v[3]  = '{8'h80, 8'h03, 5'd9,  8'hF0, 8'h00};
    v[4]  = '{8'h01, 8'h01, 5'd11, 8'h80, 8'h00};
`ifdef ALU_MULDIV_EN
    v[5]  = '{8'h10, 8'h20, 5'd12, 8'h00, 8'h02};
    v[6]  = '{8'h07, 8'h02, 5'd13, 8'h03, 8'h01};
    v[7]  = '{8'h09, 8'h00, 5'd13, 8'hFF, 8'h09};
`else
    v[5]  = '{8'h10, 8'h20, 5'd12, 8'h00, 8'h00};
    v[6]  = '{8'h07, 8'h02, 5'd13, 8'h00, 8'h00};
    v[7]  = '{8'h09, 8'h00, 5'd13, 8'h00, 8'h00};
`endif
    v[8]  = '{8'hAB, 8'hCD, 5'd20, 8'h00, 8'h00};
    v[9]  = '{8'h00, 8'h00, 5'd6,  8'h00, 8'h00};
    v[10] = '{8'h01, 8'h00, 5'd6,  8'hFF, 8'h01};
    v[11] = '{8'h81, 8'h08, 5'd7,  8'h00, 8'h00};
    v[12] = '{8'hFF, 8'h09, 5'd8,  8'h00, 8'h00};
    v[13] = '{8'h80, 8'h0C, 5'd9,  8'hFF, 8'h00};
    v[14] = '{8'h11, 8'h13, 5'd7,  8'h88, 8'h00};
    v[15] = '{8'h81, 8'h09, 5'd10, 8'h03, 8'h00};
    v[16] = '{8'h3C, 8'hA5, 5'd31, 8'h00, 8'h00};
    for (int i = 0; i < 17; i++) begin
      drive(v[i].a, v[i].b, v[i].op);
      @(posedge clk); #1;
      n_checks++;
      if ({out_res_rc, carryout} !== {v[i].r, v[i].c}) begin
        n_fail++;
        $display("FAIL directed[%0d] op=%0d a=%h b=%h: got %h/%h want %h/%h",
                 i, v[i].op, v[i].a, v[i].b, out_res_rc, carryout, v[i].r, v[i].c);
      end
    end
  endtask

  task automatic test_random;
    int r, c;
    logic [7:0] a, b;
    logic [4:0] op;
    for (int i = 0; i < 400; i++) begin
      a  = 8'($urandom);
      b  = (i % 3 == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom);
      op = (i % 4 == 0) ? 5'($urandom) : 5'($urandom_range(0, 15));
      model(int'(a), int'(b), int'(op), r, c);
      drive(a, b, op);
      @(posedge clk); #1;
      n_checks++;
      if (out_res_rc !== 8'(r) || carryout !== 8'(c)) begin
        n_fail++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h: got %h/%h want %h/%h",
                 i, op, a, b, out_res_rc, carryout, 8'(r), 8'(c));
      end
    end
  endtask

  task automatic test_hold;
    drive(8'h40, 8'h30, 5'd4);
    @(posedge clk); #1;
    in_a = 8'hFF; in_b = 8'h01; in_c = 5'd0;
    #2;
    n_checks++;
    if ({out_res_rc, carryout} !== {8'h70, 8'h00}) begin
      n_fail++;
      $display("FAIL hold: got %h/%h want 70/00", out_res_rc, carryout);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({out_res_rc, carryout} !== {8'h00, 8'h01}) begin
      n_fail++;
      $display("FAIL hold_next: got %h/%h want 00/01", out_res_rc, carryout);
    end
  endtask

  task automatic test_reset_midcycle;
    drive(8'h05, 8'h02, 5'd0);
    @(posedge clk); #1;
    n_checks++;
    if (out_res_rc !== 8'h07) begin
      n_fail++;
      $display("FAIL pre_reset: got %h want 07", out_res_rc);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out_res_rc, carryout} !== 16'h0000) begin
      n_fail++;
      $display("FAIL async_reset: got %h/%h want 00/00", out_res_rc, carryout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #3;
    n_checks++;
    if ({out_res_rc, carryout} !== 16'h0000) begin
      n_fail++;
      $display("FAIL post_release: got %h/%h want 00/00", out_res_rc, carryout);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({out_res_rc, carryout} !== {8'h07, 8'h00}) begin
      n_fail++;
      $display("FAIL first_capture: got %h/%h want 07/00", out_res_rc, carryout);
    end
  endtask

  task automatic test_back_to_back;
    vec_t v[4];
    v[0] = '{8'hF0, 8'h0F, 5'd3,  8'hFF, 8'h00};
    v[1] = '{8'h10, 8'h20, 5'd1,  8'hF0, 8'h01};
    v[2] = '{8'h5A, 8'h00, 5'd5,  8'hA5, 8'h00};
    v[3] = '{8'h12, 8'h34, 5'd15, 8'h34, 8'h00};
    for (int i = 0; i < 4; i++) begin
      drive(v[i].a, v[i].b, v[i].op);
      @(posedge clk); #1;
      n_checks++;
      if ({out_res_rc, carryout} !== {v[i].r, v[i].c}) begin
        n_fail++;
        $display("FAIL b2b[%0d]: got %h/%h want %h/%h",
                 i, out_res_rc, carryout, v[i].r, v[i].c);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_back_to_back();
    test_random();
    test_reset_midcycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
